// File: rtl/imm_field_decoder.sv
// Immediate field decoder: extracts raw RV32I immediates and the extender select behind a
// registered output stage with a one-entry skid buffer. Optional macro: IMM_ILLEGAL_DETECT_EN.
module imm_field_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] Imm12,
    output logic [19:0] Imm20,
    output logic [1:0]  CTRL,
    output logic        HasImm,
    output logic        IllegalOp,
    output logic [15:0] InstrCount
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [1:0] SEL_IMM12     = 2'b00;
    localparam logic [1:0] SEL_IMM12_SH1 = 2'b01;
    localparam logic [1:0] SEL_IMM20     = 2'b10;
    localparam logic [1:0] SEL_IMM20_SH1 = 2'b11;

    typedef struct packed {
        logic [11:0] imm12;
        logic [19:0] imm20;
        logic [1:0]  ctrl;
        logic        has_imm;
    } dec_t;

    localparam dec_t DEC_NONE = '{imm12: 12'd0, imm20: 20'd0, ctrl: 2'b00, has_imm: 1'b0};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    // Pure field extraction; R-type, FENCE and unknown opcodes keep the all-zero word.
    function automatic dec_t decode_fields(input logic [31:0] w);
        dec_t d;
        d = DEC_NONE;
        case (w[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                d.imm12   = w[31:20];
                d.ctrl    = SEL_IMM12;
                d.has_imm = 1'b1;
            end
            OP_STORE: begin
                d.imm12   = {w[31:25], w[11:7]};
                d.ctrl    = SEL_IMM12;
                d.has_imm = 1'b1;
            end
            OP_BRANCH: begin
                d.imm12   = {w[31], w[7], w[30:25], w[11:8]};
                d.ctrl    = SEL_IMM12_SH1;
                d.has_imm = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                d.imm20   = w[31:12];
                d.ctrl    = SEL_IMM20;
                d.has_imm = 1'b1;
            end
            OP_JAL: begin
                d.imm20   = {w[31], w[19:12], w[20], w[30:21]};
                d.ctrl    = SEL_IMM20_SH1;
                d.has_imm = 1'b1;
            end
            OP_REG, OP_FENCE: begin
                d = DEC_NONE;
            end
            default: begin
                d = DEC_NONE;
            end
        endcase
        return d;
    endfunction

`ifdef IMM_ILLEGAL_DETECT_EN
    // Flags any opcode outside the supported RV32I base list.
    function automatic logic opcode_unlisted(input logic [6:0] op);
        logic bad;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_FENCE: bad = 1'b0;
            default:                                     bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

    state_t      state_r;
    state_t      state_next_s;
    dec_t        dec_s;
    dec_t        out_r;
    dec_t        skid_r;
    logic        out_valid_r;
    logic        in_ready_r;
    logic [15:0] count_r;
    logic        accept_s;
    logic        drain_s;
    logic        load_out_in_s;
    logic        load_out_skid_s;
    logic        load_skid_s;

    assign dec_s    = decode_fields(Instr);
    assign accept_s = in_valid & in_ready_r;
    assign drain_s  = out_valid_r & out_ready;

    // Occupancy next-state and register load selects.
    always_comb begin
        state_next_s    = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    load_out_in_s = 1'b1;
                    state_next_s  = ST_ONE;
                end else begin
                    state_next_s  = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    load_out_in_s = 1'b1;
                    state_next_s  = ST_ONE;
                end else if (accept_s) begin
                    load_skid_s   = 1'b1;
                    state_next_s  = ST_FULL;
                end else if (drain_s) begin
                    state_next_s  = ST_EMPTY;
                end else begin
                    state_next_s  = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can move the state.
                if (drain_s) begin
                    load_out_skid_s = 1'b1;
                    state_next_s    = ST_ONE;
                end else begin
                    state_next_s    = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // State, handshake flags, data registers and accept counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_r       <= DEC_NONE;
            skid_r      <= DEC_NONE;
            count_r     <= 16'd0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s != ST_EMPTY);
            in_ready_r  <= (state_next_s != ST_FULL);
            if (load_out_in_s) begin
                out_r <= dec_s;
            end else if (load_out_skid_s) begin
                out_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= dec_s;
            end
            if (accept_s) begin
                count_r <= count_r + 16'd1;
            end
        end
    end

`ifdef IMM_ILLEGAL_DETECT_EN
    logic out_illegal_r;
    logic skid_illegal_r;
    logic in_illegal_s;

    assign in_illegal_s = opcode_unlisted(Instr[6:0]);

    // Illegal flag travels alongside its decoded word through OUT and SKID.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_illegal_r  <= 1'b0;
            skid_illegal_r <= 1'b0;
        end else begin
            if (load_out_in_s) begin
                out_illegal_r <= in_illegal_s;
            end else if (load_out_skid_s) begin
                out_illegal_r <= skid_illegal_r;
            end
            if (load_skid_s) begin
                skid_illegal_r <= in_illegal_s;
            end
        end
    end

    assign IllegalOp = out_illegal_r;
`else
    assign IllegalOp = 1'b0;
`endif

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign Imm12      = out_r.imm12;
    assign Imm20      = out_r.imm20;
    assign CTRL       = out_r.ctrl;
    assign HasImm     = out_r.has_imm;
    assign InstrCount = count_r;

endmodule

// File: tb/tb_imm_field_decoder.sv
// Randomized and directed bench for imm_field_decoder against a queue-based reference model.
module tb_imm_field_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Instr;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] Imm12;
    logic [19:0] Imm20;
    logic [1:0]  CTRL;
    logic        HasImm;
    logic        IllegalOp;
    logic [15:0] InstrCount;

    imm_field_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Instr      (Instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Imm12      (Imm12),
        .Imm20      (Imm20),
        .CTRL       (CTRL),
        .HasImm     (HasImm),
        .IllegalOp  (IllegalOp),
        .InstrCount (InstrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IMM_ILLEGAL_DETECT_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [11:0] i12;
        logic [19:0] i20;
        logic [1:0]  c;
        logic        h;
        logic        il;
    } exp_t;

    exp_t        q[$];
    int          acc_count;
    int unsigned n_checks;
    int unsigned n_errors;

    logic [6:0] opcodes [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h7F};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: architectural immediate per format, then the raw field the extender wants.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t        e;
        logic [12:0] boff;
        logic [20:0] joff;
        e.i12 = 12'd0; e.i20 = 20'd0; e.c = 2'd0; e.h = 1'b0; e.il = 1'b0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin e.i12 = w[31:20]; e.h = 1'b1; end
            7'h23: begin e.i12 = {w[31:25], w[11:7]}; e.h = 1'b1; end
            7'h63: begin
                boff = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                e.i12 = boff[12:1]; e.c = 2'd1; e.h = 1'b1;
            end
            7'h37, 7'h17: begin e.i20 = w[31:12]; e.c = 2'd2; e.h = 1'b1; end
            7'h6F: begin
                joff = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                e.i20 = joff[20:1]; e.c = 2'd3; e.h = 1'b1;
            end
            7'h33, 7'h0F: e.h = 1'b0;
            default: e.il = ILL_EN;
        endcase
        return e;
    endfunction

    task automatic compare_model();
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        check_eq("count", {16'd0, InstrCount}, acc_count);
        if (q.size() > 0) begin
            check_eq("imm12", {20'd0, Imm12}, {20'd0, q[0].i12});
            check_eq("imm20", {12'd0, Imm20}, {12'd0, q[0].i20});
            check_eq("ctrl", {30'd0, CTRL}, {30'd0, q[0].c});
            check_eq("hasimm", {31'd0, HasImm}, {31'd0, q[0].h});
            check_eq("illegal", {31'd0, IllegalOp}, {31'd0, q[0].il});
        end
    endtask

    // One cycle: check outputs at negedge, drive inputs, advance the model at posedge.
    task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic r);
        bit acc;
        bit drn;
        @(negedge clk);
        compare_model();
        in_valid = v; Instr = w; out_ready = ordy; rst = r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            acc_count = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_decode(Instr));
                acc_count = (acc_count + 1) % 65536;
            end
        end
    endtask

    task automatic expect_fields(input string tag, input logic [11:0] i12, input logic [19:0] i20,
                                 input logic [1:0] c, input logic h);
        #1;
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_imm12"}, {20'd0, Imm12}, {20'd0, i12});
        check_eq({tag, "_imm20"}, {12'd0, Imm20}, {12'd0, i20});
        check_eq({tag, "_ctrl"}, {30'd0, CTRL}, {30'd0, c});
        check_eq({tag, "_hasimm"}, {31'd0, HasImm}, {31'd0, h});
    endtask

    initial begin
        logic [31:0] w;
        n_checks = 0; n_errors = 0; acc_count = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Instr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_imm12", {20'd0, Imm12}, 32'd0);
        check_eq("rst_imm20", {12'd0, Imm20}, 32'd0);
        check_eq("rst_ctrl", {30'd0, CTRL}, 32'd0);
        check_eq("rst_hasimm", {31'd0, HasImm}, 32'd0);
        check_eq("rst_illegal", {31'd0, IllegalOp}, 32'd0);
        check_eq("rst_count", {16'd0, InstrCount}, 32'd0);

        // Directed decode vectors from the reference encodings.
        step(1'b1, 32'hFFF00093, 1'b1, 1'b0); expect_fields("addi", 12'hFFF, 20'h0, 2'd0, 1'b1);
        step(1'b1, 32'hFE000EE3, 1'b1, 1'b0); expect_fields("beq", 12'hFFE, 20'h0, 2'd1, 1'b1);
        step(1'b1, 32'h0080006F, 1'b1, 1'b0); expect_fields("jal", 12'h0, 20'h00004, 2'd3, 1'b1);
        step(1'b1, 32'h123450B7, 1'b1, 1'b0); expect_fields("lui", 12'h0, 20'h12345, 2'd2, 1'b1);
        step(1'b1, 32'h002081B3, 1'b1, 1'b0); expect_fields("add", 12'h0, 20'h0, 2'd0, 1'b0);
        step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        #1 check_eq("op7f_illegal", {31'd0, IllegalOp}, {31'd0, ILL_EN});
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Backpressure: two words stored, in_ready drops, release drains in order.
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        #1 check_eq("bp_ready_one", {31'd0, in_ready}, 32'd1);
        step(1'b1, 32'h123450B7, 1'b0, 1'b0);
        #1 check_eq("bp_ready_full", {31'd0, in_ready}, 32'd0);
        expect_fields("bp_first", 12'hFFF, 20'h0, 2'd0, 1'b1);
        step(1'b1, 32'h002081B3, 1'b0, 1'b0);
        expect_fields("bp_hold", 12'hFFF, 20'h0, 2'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        expect_fields("bp_second", 12'h0, 20'h12345, 2'd2, 1'b1);
        check_eq("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        #1 check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

        // Randomized traffic with random stalls.
        for (int i = 0; i < 2000; i++) begin
            w = $urandom;
            w[6:0] = opcodes[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) w[6:0] = 7'($urandom);
            step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0), 1'b0);
        end

        // Reset while FULL discards both entries and ignores same-cycle handshakes.
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        step(1'b1, 32'h123450B7, 1'b0, 1'b0);
        #1 check_eq("full_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 32'h0080006F, 1'b1, 1'b1);
        #1;
        check_eq("rstfull_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rstfull_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rstfull_count", {16'd0, InstrCount}, 32'd0);

        // Counter wrap after 65536 accepts.
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 32'h00100093 + 32'(i[10:0]) * 32'h00100000, 1'b1, 1'b0);
        end
        #1 check_eq("count_wrap", {16'd0, InstrCount}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_field_decoder.md
# imm_field_decoder

Decode-stage producer for the immediate sign extender. Accepts 32-bit RV32I instruction words over a valid/ready handshake, extracts the raw immediate bits into `Imm12` or `Imm20`, and emits the 2-bit `CTRL` select the extender consumes. Output is registered, with a one-entry skid buffer so `in_ready` is a pure register output. Sits between instruction fetch and the extender in each core.

## Interface
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  instruction word valid
- `in_ready`  out  1  block can accept; registered, equals "skid buffer empty"
- `Instr`  in  32  instruction word
- `out_valid`  out  1  decoded fields valid
- `out_ready`  in  1  downstream accepts
- `Imm12`  out  12  raw 12-bit immediate (I/S/B formats)
- `Imm20`  out  20  raw 20-bit immediate (U/J formats)
- `CTRL`  out  2  extender select: 00 Imm12, 01 Imm12<<1, 10 Imm20, 11 Imm20<<1
- `HasImm`  out  1  instruction carries an immediate
- `IllegalOp`  out  1  unrecognised opcode (only with `IMM_ILLEGAL_DETECT_EN`; otherwise tied 0)
- `InstrCount`  out  16  count of accepted instructions

## Operation
- Decode on `Instr[6:0]`. Unused immediate output is driven 0.
  - I-type (`0010011`, `0000011`, `1100111`, `1110011`): `Imm12=Instr[31:20]`, `CTRL=00`, `HasImm=1`.
  - S-type (`0100011`): `Imm12={Instr[31:25],Instr[11:7]}`, `CTRL=00`, `HasImm=1`.
  - B-type (`1100011`): `Imm12={Instr[31],Instr[7],Instr[30:25],Instr[11:8]}`, `CTRL=01`, `HasImm=1`.
  - U-type (`0110111`, `0010111`): `Imm20=Instr[31:12]`, `CTRL=10`, `HasImm=1`. Downstream applies the <<12 shift.
  - J-type (`1101111`): `Imm20={Instr[31],Instr[19:12],Instr[20],Instr[30:21]}`, `CTRL=11`, `HasImm=1`.
  - R-type (`0110011`), FENCE (`0001111`): all immediates 0, `CTRL=00`, `HasImm=0`.
  - Any other opcode: as R-type. `IllegalOp=1` when the macro is enabled.
- Storage: output register (OUT) and skid register (SKID), each with a valid bit. Decoding happens before storage, so both registers hold decoded fields.
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- States by {OUT valid, SKID valid}:
  - EMPTY (0,0): accept loads OUT → ONE.
  - ONE (1,0):
    - accept and drain: OUT reloads, stays ONE.
    - accept, no drain: load SKID → FULL.
    - drain only → EMPTY.
  - FULL (1,1): `in_ready=0`. Drain moves SKID to OUT → ONE. No other transition.
- `InstrCount` increments on every accept and wraps 0xFFFF → 0x0000.
- Order is strictly preserved. No word is dropped or duplicated.

## Timing
- Reset values:
  - `out_valid=0`, `in_ready=1`
  - `Imm12=0`, `Imm20=0`, `CTRL=00`
  - `HasImm=0`, `IllegalOp=0`, `InstrCount=0`
  - SKID invalid
- Latency: a word accepted at edge N is presented on the outputs after edge N (visible in cycle N+1).
- Throughput: one word per cycle while `out_ready=1`.
- `in_ready` falls the cycle after SKID fills and rises the cycle after SKID drains into OUT.
- While `out_valid=1` and `out_ready=0`, all outputs hold stable.
- Reset asserted mid-transfer discards OUT and SKID contents at the next edge. Handshakes in that cycle are ignored and the count is not incremented.

## Configuration
- `IMM_ILLEGAL_DETECT_EN` defined: the full opcode list above is checked, and unlisted opcodes raise `IllegalOp` alongside their decoded word.
- Not defined: no opcode check logic is built, `IllegalOp` is constant 0, and unlisted opcodes decode as R-type.

## Test plan
- `ADDI` 0xFFF00093 → `Imm12=0xFFF`, `CTRL=00`, `HasImm=1`, `out_valid` high one cycle after accept.
- `BEQ` 0xFE000EE3 → `Imm12=0xFFE` (offset −4 after extender <<1), `CTRL=01`. `JAL` 0x0080006F → `Imm20=0x00004`, `CTRL=11`.
- `LUI` 0x123450B7 → `Imm20=0x12345`, `CTRL=10`. `ADD` 0x002081B3 → `HasImm=0`, all immediate fields 0.
- Backpressure: `out_ready=0`, two words offered back-to-back → both stored, `in_ready=0` from cycle 3. Release `out_ready` → outputs appear in order and `in_ready` returns to 1.
- Opcode 0x7F with macro defined → `IllegalOp=1`. Without the macro → `IllegalOp=0`.
- 65536 accepts → `InstrCount` wraps to 0. `rst` asserted with FULL → next cycle `out_valid=0`, `in_ready=1`, `InstrCount=0`.
